// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic       Zero;
    logic       MdDone;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       MdStart;

    modport master (
        input  op, funct3, funct7b5, funct7b0, Zero, MdDone,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, MdStart
    );

    modport slave (
        output op, funct3, funct7b5, funct7b0, Zero, MdDone,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, MdStart
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32 datapath with registered state-derived outputs.
// Optional mul/div sequencing (MDWAIT state, MdStart pulse) is enabled by defining MULDIV_EN.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
`ifdef MULDIV_EN
        , MDWAIT = 4'd11
`endif
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    state_t     load_state_s;
    logic       irwrite_r, regwrite_r, memwrite_r, adrsrc_r;
    logic       pcupdate_r, branch_r, mdstart_r;
    logic [1:0] resultsrc_r, alusrca_r, alusrcb_r, alu_op_r;
    logic [1:0] immsrc_s;
    logic [2:0] alu_control_s;

    // Next-state selection; illegal encodings fall back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:    next_state_s = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
`ifdef MULDIV_EN
                    OP_R:         next_state_s = bus.funct7b0 ? MDWAIT : EXECUTER;
`else
                    OP_R:         next_state_s = bus.funct7b0 ? FETCH : EXECUTER;
`endif
                    OP_I:         next_state_s = EXECUTEI;
                    OP_JAL:       next_state_s = JAL;
                    OP_BEQ:       next_state_s = BEQ;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR:   next_state_s = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state_s = MEMWB;
            MEMWB:    next_state_s = FETCH;
            MEMWRITE: next_state_s = FETCH;
            EXECUTER: next_state_s = ALUWB;
            EXECUTEI: next_state_s = ALUWB;
            ALUWB:    next_state_s = FETCH;
            JAL:      next_state_s = ALUWB;
            BEQ:      next_state_s = FETCH;
`ifdef MULDIV_EN
            MDWAIT:   next_state_s = bus.MdDone ? ALUWB : MDWAIT;
`endif
            default:  next_state_s = FETCH;
        endcase
    end

    // Outputs are loaded for the state being entered, so reset loads the FETCH set.
    always_comb begin
        load_state_s = reset ? FETCH : next_state_s;
    end

    // State register plus registered Moore outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
        irwrite_r   <= 1'b0;
        regwrite_r  <= 1'b0;
        memwrite_r  <= 1'b0;
        adrsrc_r    <= 1'b0;
        pcupdate_r  <= 1'b0;
        branch_r    <= 1'b0;
        mdstart_r   <= 1'b0;
        resultsrc_r <= 2'b00;
        alusrca_r   <= 2'b00;
        alusrcb_r   <= 2'b00;
        alu_op_r    <= AOP_ADD;
        case (load_state_s)
            FETCH: begin
                irwrite_r   <= 1'b1;
                pcupdate_r  <= 1'b1;
                alusrcb_r   <= 2'b10;
                resultsrc_r <= 2'b10;
            end
            DECODE: begin
                alusrca_r <= 2'b01;
                alusrcb_r <= 2'b01;
            end
            MEMADR: begin
                alusrca_r <= 2'b10;
                alusrcb_r <= 2'b01;
            end
            MEMREAD:  adrsrc_r <= 1'b1;
            MEMWB: begin
                resultsrc_r <= 2'b01;
                regwrite_r  <= 1'b1;
            end
            MEMWRITE: begin
                adrsrc_r   <= 1'b1;
                memwrite_r <= 1'b1;
            end
            EXECUTER: begin
                alusrca_r <= 2'b10;
                alu_op_r  <= AOP_R;
            end
            EXECUTEI: begin
                alusrca_r <= 2'b10;
                alusrcb_r <= 2'b01;
                alu_op_r  <= AOP_R;
            end
            ALUWB: begin
                regwrite_r <= 1'b1;
`ifdef MULDIV_EN
                resultsrc_r <= (state_r == MDWAIT) ? 2'b11 : 2'b00;
`endif
            end
            JAL: begin
                alusrca_r  <= 2'b01;
                alusrcb_r  <= 2'b10;
                pcupdate_r <= 1'b1;
            end
            BEQ: begin
                alusrca_r <= 2'b10;
                alu_op_r  <= AOP_SUB;
                branch_r  <= 1'b1;
            end
`ifdef MULDIV_EN
            MDWAIT:   mdstart_r <= (state_r != MDWAIT);
`endif
            default: begin
                irwrite_r   <= 1'b1;
                pcupdate_r  <= 1'b1;
                alusrcb_r   <= 2'b10;
                resultsrc_r <= 2'b10;
            end
        endcase
    end

    // Immediate format is a pure opcode decode.
    always_comb begin
        immsrc_s = 2'b00;
        case (bus.op)
            OP_SW:   immsrc_s = 2'b01;
            OP_BEQ:  immsrc_s = 2'b10;
            OP_JAL:  immsrc_s = 2'b11;
            default: immsrc_s = 2'b00;
        endcase
    end

    // ALU operation; R/I ops decode funct3 with op[5] distinguishing sub from addi.
    always_comb begin
        alu_control_s = 3'b000;
        case (alu_op_r)
            AOP_SUB: alu_control_s = 3'b001;
            AOP_R: begin
                case (bus.funct3)
                    3'b000:  alu_control_s = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_s = 3'b101;
                    3'b110:  alu_control_s = 3'b011;
                    3'b111:  alu_control_s = 3'b010;
                    default: alu_control_s = 3'b000;
                endcase
            end
            default: alu_control_s = 3'b000;
        endcase
    end

    assign bus.PCWrite    = pcupdate_r | (branch_r & bus.Zero);
    assign bus.IRWrite    = irwrite_r;
    assign bus.RegWrite   = regwrite_r;
    assign bus.MemWrite   = memwrite_r;
    assign bus.AdrSrc     = adrsrc_r;
    assign bus.ResultSrc  = resultsrc_r;
    assign bus.ALUSrcA    = alusrca_r;
    assign bus.ALUSrcB    = alusrcb_r;
    assign bus.ImmSrc     = immsrc_s;
    assign bus.ALUControl = alu_control_s;
`ifdef MULDIV_EN
    assign bus.MdStart    = mdstart_r;
`else
    assign bus.MdStart    = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: per-instruction cycle plans are
// queued by the stimulus process and popped/compared by an independent monitor.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [16:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == OP_SW) return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation the instruction asks for, from its fields.
    function automatic logic [2:0] ralu(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        if (f3 == 3'd0) return (op == OP_R && f7b5) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    function automatic exp_t mk(input string tag, input logic [1:0] imm,
                                input logic pcw, input logic irw, input logic rw, input logic mw,
                                input logic adr, input logic [1:0] rs, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [2:0] alu, input logic mds);
        exp_t e;
        e.v   = {pcw, irw, rw, mw, adr, rs, sa, sb, imm, alu, mds};
        e.tag = tag;
        return e;
    endfunction

    // Reference: the cycle-by-cycle control word sequence of one instruction.
    task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                              input logic f7b0, input logic zbeq, input int w);
        logic [1:0] im;
        im = imm_of(op);
        plan.delete();
        plan.push_back(mk("FETCH",  im, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0));
        plan.push_back(mk("DECODE", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd0, 1'b0));
        if (op == OP_LW || op == OP_SW) begin
            plan.push_back(mk("MEMADR", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 1'b0));
            if (op == OP_LW) begin
                plan.push_back(mk("MEMREAD", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
                plan.push_back(mk("MEMWB",   im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0));
            end else begin
                plan.push_back(mk("MEMWRITE", im, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
            end
        end else if (op == OP_R && f7b0) begin
            if (MD_ON) begin
                plan.push_back(mk("MDWAIT0", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1));
                for (int k = 0; k < w; k++)
                    plan.push_back(mk("MDWAIT", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
                plan.push_back(mk("MDWB", im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 3'd0, 1'b0));
            end
        end else if (op == OP_R || op == OP_I) begin
            plan.push_back(mk("EXEC", im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2,
                              (op == OP_R) ? 2'd0 : 2'd1, ralu(op, f3, f7b5), 1'b0));
            plan.push_back(mk("ALUWB", im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        end else if (op == OP_JAL) begin
            plan.push_back(mk("JAL",   im, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 1'b0));
            plan.push_back(mk("ALUWB", im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        end else if (op == OP_BEQ) begin
            plan.push_back(mk("BEQ", im, zbeq, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0));
        end
    endtask

    // Drive one instruction; abort_at >= 0 asserts reset during that cycle of it.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                             input logic f7b0, input int w, input int zsel, input int abort_at);
        logic zbeq;
        int   last;
        bit   mul;
        zbeq = (zsel < 0) ? logic'($urandom_range(1, 0)) : logic'(zsel);
        mul  = MD_ON && op == OP_R && f7b0;
        plan_instr(op, f3, f7b5, f7b0, zbeq, w);
        last = (abort_at >= 0 && abort_at < plan.size()) ? abort_at : plan.size() - 1;
        for (int i = 0; i <= last; i++) exp_q.push_back(plan[i]);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7b5;
        bus.funct7b0 = f7b0;
        for (int i = 0; i <= last; i++) begin
            bus.Zero = (i == 2) ? zbeq : logic'($urandom_range(1, 0));
            if (mul && i >= 2) bus.MdDone = (i == 2 + w);
            else bus.MdDone = logic'($urandom_range(1, 0));
            if (i == abort_at) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        if (reset) begin
            exp_q.push_back(mk("RESET", imm_of(op), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                               2'd2, 2'd0, 2'd2, 3'd0, 1'b0));
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t        e;
        logic [16:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                       bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                       bus.MdStart};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %b want %b (pcw irw rw mw adr rs sa sb imm alu mds)",
                             e.tag, act, e.v);
                end
            end
        end
    end

    initial begin
        logic [6:0] op;
        int         kind;
        int         ab;
        reset        = 1'b1;
        bus.op       = OP_JAL;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.funct7b0 = 1'b0;
        bus.Zero     = 1'b1;
        bus.MdDone   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk("RESET", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LW,    3'd2, 1'b0, 1'b0, 0, -1, -1);
        run_instr(OP_SW,    3'd2, 1'b1, 1'b0, 0, -1, -1);
        run_instr(OP_BEQ,   3'd0, 1'b0, 1'b0, 0,  1, -1);
        run_instr(OP_BEQ,   3'd0, 1'b0, 1'b0, 0,  0, -1);
        run_instr(OP_R,     3'd0, 1'b1, 1'b0, 0, -1, -1);
        run_instr(OP_I,     3'd0, 1'b1, 1'b0, 0, -1, -1);
        run_instr(7'h7f,    3'd0, 1'b0, 1'b0, 0, -1, -1);
        run_instr(OP_SW,    3'd0, 1'b0, 1'b0, 0, -1, 3);
        run_instr(OP_R,     3'd0, 1'b0, 1'b1, 5, -1, -1);
        run_instr(OP_R,     3'd7, 1'b0, 1'b1, 0, -1, -1);
        run_instr(OP_R,     3'd0, 1'b0, 1'b1, 3, -1, 3);
        run_instr(OP_JAL,   3'd5, 1'b1, 1'b1, 0, -1, -1);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(7, 0);
            case (kind)
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_JAL;
                5: op = OP_BEQ;
                6: op = 7'($urandom);
                default: op = OP_R;
            endcase
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
            run_instr(op, 3'($urandom), 1'($urandom),
                      (kind == 7) ? 1'b1 : ((kind == 2) ? 1'b0 : 1'($urandom)),
                      int'($urandom_range(4, 0)), -1, ab);
        end

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
- REQ-001: Parameters: none; all encodings below are fixed.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: op  input  7  instruction opcode (Instr[6:0]).
- REQ-005: funct3  input  3  Instr[14:12].
- REQ-006: funct7b5  input  1  Instr[30].
- REQ-007: funct7b0  input  1  Instr[25]; selects M-extension.
- REQ-008: Zero  input  1  ALU zero flag.
- REQ-009: MdDone  input  1  mul/div unit result valid.
- REQ-010: PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/select.
- REQ-011: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
- REQ-012: ALUControl  output  3  ALU operation.
- REQ-013: MdStart  output  1  one-cycle start pulse to the mul/div unit.

Function
- REQ-014: Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, MDWAIT. All unlisted outputs in a state are 0.
- REQ-015: Encodings: ALUSrcA 00=PC, 01=OldPC, 10=RD1. ALUSrcB 00=RD2, 01=ImmExt, 10=4. ResultSrc 00=ALUOut, 01=Data, 10=ALUResult, 11=MdResult. AdrSrc 0=PC, 1=Result.
- REQ-016: FETCH: IRWrite=1, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1; next state DECODE.
- REQ-017: DECODE: ALUSrcA=01, ALUSrcB=01, add. Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH, with no register, memory or PC write.
- REQ-018: MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state: op[5]=0 -> MEMREAD, else MEMWRITE.
- REQ-019: MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1 -> FETCH. MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
- REQ-020: EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=R. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=R. Both go to ALUWB. ALUWB: RegWrite=1 -> FETCH.
- REQ-021: JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1 -> ALUWB. BEQ: ALUSrcA=10, ALUSrcB=00, sub, Branch=1 -> FETCH.
- REQ-022: PCWrite = PCUpdate | (Branch & Zero); combinational from state and Zero.
- REQ-023: ImmSrc depends on op only: 0000011/0010011 -> 00 (I); 0100011 -> 01 (S); 1100011 -> 10 (B); 1101111 -> 11 (J); any other op -> 00.
- REQ-024: ALUControl for ALUOp=R, by funct3:
  - 000: sub when op[5]&funct7b5, else add.
  - 010: slt (101).
  - 110: or (011).
  - 111: and (010).
  - any other funct3: add.
  - Encodings: add=000, sub=001.
- REQ-025: Exactly one state active per cycle; unreachable encodings recover to FETCH on the next edge.

Reset
- REQ-026: reset high at a rising edge forces state FETCH and takes priority over every transition, including mid-instruction and in MDWAIT.
- REQ-027: While in reset and the cycle after, outputs are FETCH-state outputs only; MemWrite, RegWrite and MdStart are 0.

Configuration
- REQ-028: Macro MULDIV_EN.
  - Defined: in DECODE, op=0110011 with funct7b0=1 goes to MDWAIT. MdStart=1 in the first MDWAIT cycle only. The FSM stays in MDWAIT until MdDone=1, including when MdDone arrives in the first cycle. It then goes to ALUWB with ResultSrc=11.
  - Not defined: op=0110011 with funct7b0=1 is treated as illegal (DECODE -> FETCH, no writes). MDWAIT and MdStart logic are absent, MdStart is tied 0, and MdDone is ignored.

Verification
- REQ-029: Reset 2 cycles, then lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 in cycle 5 only; MemWrite never 1.
- REQ-030: sw (op=0100011) -> MemWrite=1, AdrSrc=1 in cycle 4 only; ImmSrc=01 throughout.
- REQ-031: beq with Zero=1 -> PCWrite=1 in BEQ cycle, ALUControl=001. With Zero=0 -> PCWrite=0 in BEQ cycle. Next state FETCH in both cases.
- REQ-032: R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. addi with funct7b5=1 -> ALUControl=000. op=1111111 -> DECODE then FETCH, no writes.
- REQ-033: Reset asserted during MEMWRITE -> next state FETCH, MemWrite=0 on the following cycle.
- REQ-034: With MULDIV_EN, mul with MdDone held low 5 cycles -> MdStart high 1 cycle, FSM stays in MDWAIT, then ALUWB with ResultSrc=11, RegWrite=1. Without MULDIV_EN, the same instruction gives no RegWrite.
